// File: rtl/fir_pkg.sv
// Shared types and helpers for the FIR block and its stimulus generator.
package fir_pkg;

    localparam int DATA_W_DEF = 16;

    typedef enum logic [1:0] {
        STIM_IMPULSE,
        STIM_STEP,
        STIM_SQUARE,
        STIM_RAMP
    } stim_mode_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FINISH
    } stim_state_t;

    // Two's-complement negate of a w-bit value (sign-extended into 32 bits),
    // clamping the most negative value to the most positive one.
    function automatic logic signed [31:0] sat_neg(input logic signed [31:0] a,
                                                   input int unsigned w);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo = -hi - 32'sd1;
        return (a == lo) ? hi : -a;
    endfunction

endpackage

// File: rtl/fir_stim_gen_if.sv
// Sample stream from the stimulus generator to the FIR input.
// FIR_STIM_GEN_READY_EN adds the out_ready backpressure signal.
interface fir_stim_gen_if #(
    parameter int DATA_W = 16
);
    logic                     out_valid;
    logic signed [DATA_W-1:0] out_sample;
`ifdef FIR_STIM_GEN_READY_EN
    logic                     out_ready;

    modport master (output out_valid, output out_sample, input  out_ready);
    modport slave  (input  out_valid, input  out_sample, output out_ready);
`else
    modport master (output out_valid, output out_sample);
    modport slave  (input  out_valid, input  out_sample);
`endif
endinterface

// File: rtl/fir_stim_rate_div.sv
// Reloadable down-counter producing a tick RATE_DIV cycles after each load.
// The tick comes one cycle early so a registered strobe lands on the boundary.
module fir_stim_rate_div #(
    parameter int RATE_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic tick
);
    localparam int CW = (RATE_DIV > 1) ? $clog2(RATE_DIV) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(RATE_DIV - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= RELOAD;
        end else if (en && cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    // With RATE_DIV = 1 the next strobe must follow the load cycle directly.
    assign tick = load ? (RATE_DIV == 1) : (en && cnt_q == CW'(1));

endmodule

// File: rtl/fir_stim_gen.sv
// Burst stimulus generator (impulse/step/square/ramp) feeding the FIR input.
// Build with FIR_STIM_GEN_READY_EN to honour out_ready backpressure.
module fir_stim_gen
    import fir_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int RATE_DIV = 4,
    parameter int CNT_W    = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [1:0]               mode,
    input  logic signed [DATA_W-1:0] amplitude,
    input  logic [CNT_W-1:0]         num_samples,
    input  logic [7:0]               half_period,
    output logic                     busy,
    output logic                     done,
    fir_stim_gen_if.master           stim
);
    stim_state_t              state_q, state_d;
    stim_mode_t               mode_q;
    logic signed [DATA_W-1:0] amp_q, acc_q, acc_nx, sample_q, neg_amp, wave;
    logic signed [31:0]       neg_wide;
    logic [CNT_W-1:0]         num_q, n_q, n_nx;
    logic [7:0]               per_q;
    logic [8:0]               pos_q, pos_nx, two_p;
    logic                     valid_q, ready, xfer, last, accept, load, tick;

`ifdef FIR_STIM_GEN_READY_EN
    assign ready = stim.out_ready;
`else
    assign ready = 1'b1;
`endif

    assign xfer = valid_q && ready;
    assign last = (n_q == num_q - 1'b1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        load    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = (num_samples == '0) ? ST_FINISH : ST_RUN;
                end
            end
            ST_RUN: begin
                if (xfer) begin
                    if (last) state_d = ST_FINISH;
                    else      load    = 1'b1;
                end
            end
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    fir_stim_rate_div #(.RATE_DIV(RATE_DIV)) u_rate_div (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .en    (state_q == ST_RUN && !valid_q),
        .tick  (tick)
    );

    // Waveform state as it will be after this cycle's transfer, so a tick
    // coinciding with a transfer (RATE_DIV = 1) emits the following sample.
    assign two_p  = {per_q, 1'b0};
    assign n_nx   = xfer ? n_q + 1'b1 : n_q;
    assign acc_nx = xfer ? acc_q + amp_q : acc_q;
    assign pos_nx = !xfer ? pos_q : (pos_q == two_p - 9'd1) ? '0 : pos_q + 9'd1;

    assign neg_wide = sat_neg(32'(amp_q), DATA_W);
    assign neg_amp  = neg_wide[DATA_W-1:0];

    always_comb begin
        wave = '0;
        case (mode_q)
            STIM_IMPULSE: wave = (n_nx == '0) ? amp_q : '0;
            STIM_STEP:    wave = amp_q;
            STIM_SQUARE:  wave = (pos_nx < {1'b0, per_q}) ? amp_q : neg_amp;
            STIM_RAMP:    wave = acc_nx;
            default:      wave = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q   <= STIM_IMPULSE;
            amp_q    <= '0;
            num_q    <= '0;
            per_q    <= '0;
            n_q      <= '0;
            acc_q    <= '0;
            pos_q    <= '0;
            valid_q  <= 1'b0;
            sample_q <= '0;
        end else if (accept) begin
            mode_q <= stim_mode_t'(mode);
            amp_q  <= amplitude;
            num_q  <= num_samples;
            per_q  <= (half_period == 8'd0) ? 8'd1 : half_period;
            n_q    <= '0;
            acc_q  <= '0;
            pos_q  <= '0;
            // Sample 0 is the amplitude for every mode except the ramp.
            if (num_samples != '0) begin
                valid_q  <= 1'b1;
                sample_q <= (stim_mode_t'(mode) == STIM_RAMP) ? '0 : amplitude;
            end
        end else if (state_q == ST_RUN) begin
            n_q   <= n_nx;
            acc_q <= acc_nx;
            pos_q <= pos_nx;
            if (xfer)      valid_q <= tick;
            else if (tick) valid_q <= 1'b1;
            if (tick) sample_q <= wave;
        end else begin
            valid_q <= 1'b0;
        end
    end

    assign busy            = (state_q == ST_RUN);
    assign done            = (state_q == ST_FINISH);
    assign stim.out_valid  = valid_q;
    assign stim.out_sample = valid_q ? sample_q : '0;

endmodule

// File: tb/tb_fir_stim_gen.sv
// Directed bench for fir_stim_gen at RATE_DIV = 4; the backpressure scenario
// is built only with FIR_STIM_GEN_READY_EN.
module tb_fir_stim_gen;
    logic               clk = 1'b0;
    logic               rst_n;
    logic               start;
    logic [1:0]         mode;
    logic signed [15:0] amplitude;
    logic [15:0]        num_samples;
    logic [7:0]         half_period;
    logic               busy, done;

    fir_stim_gen_if #(.DATA_W(16)) bus ();

    fir_stim_gen #(.DATA_W(16), .RATE_DIV(4), .CNT_W(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .mode        (mode),
        .amplitude   (amplitude),
        .num_samples (num_samples),
        .half_period (half_period),
        .busy        (busy),
        .done        (done),
        .stim        (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic signed [15:0] samples[$];
    int                 cycles[$];
    int                 done_cyc, done_cnt;
    logic               busy_at_done, busy_c1;

    // Runs one burst, recording every transfer and its cycle index (cycle 1 is
    // the cycle after the accepting edge). start is re-pulsed at cycle start_at.
    task automatic run_burst(input logic [1:0] m, input logic signed [15:0] a,
                             input logic [15:0] n, input logic [7:0] hp,
                             input int budget, input int start_at);
        samples.delete();
        cycles.delete();
        done_cyc = -1; done_cnt = 0; busy_at_done = 1'b0; busy_c1 = 1'b0;
        @(negedge clk);
        mode = m; amplitude = a; num_samples = n; half_period = hp; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= budget; c++) begin
            start = (c == start_at);
            if (c == 1) busy_c1 = busy;
            if (bus.out_valid) begin
                samples.push_back(bus.out_sample);
                cycles.push_back(c);
            end
            if (done) begin
                if (done_cyc < 0) done_cyc = c;
                if (busy) busy_at_done = 1'b1;
                done_cnt++;
            end
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks += 4;
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.out_valid); end
        if (bus.out_sample !== 16'sd0) begin failures++; $display("FAIL reset_sample got=%0d exp=0", bus.out_sample); end
        rst_n = 1'b1;
    endtask

    task automatic test_impulse();
        run_burst(2'd0, 16'sd1, 16'd10, 8'd0, 44, 0);
        checks += 4;
        if (samples.size() != 10) begin failures++; $display("FAIL impulse_count got=%0d exp=10", samples.size()); end
        if (busy_c1 !== 1'b1) begin failures++; $display("FAIL impulse_busy_c1 got=%b exp=1", busy_c1); end
        if (done_cyc != 38) begin failures++; $display("FAIL impulse_done_cyc got=%0d exp=38", done_cyc); end
        if (busy_at_done !== 1'b0) begin failures++; $display("FAIL impulse_busy_at_done got=%b exp=0", busy_at_done); end
        for (int i = 0; i < samples.size() && i < 10; i++) begin
            checks += 2;
            if (samples[i] !== ((i == 0) ? 16'sd1 : 16'sd0)) begin
                failures++; $display("FAIL impulse_sample[%0d] got=%0d exp=%0d", i, samples[i], (i == 0) ? 1 : 0);
            end
            if (cycles[i] != 1 + 4 * i) begin
                failures++; $display("FAIL impulse_cycle[%0d] got=%0d exp=%0d", i, cycles[i], 1 + 4 * i);
            end
        end
    endtask

    task automatic test_square();
        logic signed [15:0] exp_a[8] = '{16'sd100, 16'sd100, -16'sd100, -16'sd100,
                                         16'sd100, 16'sd100, -16'sd100, -16'sd100};
        logic signed [15:0] exp_b[4] = '{16'sh8000, 16'sh8000, 16'sh7fff, 16'sh7fff};
        logic signed [15:0] exp_c[4] = '{16'sd5, -16'sd5, 16'sd5, -16'sd5};
        run_burst(2'd2, 16'sd100, 16'd8, 8'd2, 36, 0);
        checks++;
        if (samples.size() != 8) begin failures++; $display("FAIL square_count got=%0d exp=8", samples.size()); end
        for (int i = 0; i < samples.size() && i < 8; i++) begin
            checks++;
            if (samples[i] !== exp_a[i]) begin failures++; $display("FAIL square_sample[%0d] got=%0d exp=%0d", i, samples[i], exp_a[i]); end
        end
        run_burst(2'd2, 16'sh8000, 16'd4, 8'd2, 20, 0);
        checks++;
        if (samples.size() != 4) begin failures++; $display("FAIL square_min_count got=%0d exp=4", samples.size()); end
        for (int i = 0; i < samples.size() && i < 4; i++) begin
            checks++;
            if (samples[i] !== exp_b[i]) begin failures++; $display("FAIL square_min_sample[%0d] got=%0d exp=%0d", i, samples[i], exp_b[i]); end
        end
        // half_period 0 behaves as 1: alternate every sample.
        run_burst(2'd2, 16'sd5, 16'd4, 8'd0, 20, 0);
        checks++;
        if (samples.size() != 4) begin failures++; $display("FAIL square_hp0_count got=%0d exp=4", samples.size()); end
        for (int i = 0; i < samples.size() && i < 4; i++) begin
            checks++;
            if (samples[i] !== exp_c[i]) begin failures++; $display("FAIL square_hp0_sample[%0d] got=%0d exp=%0d", i, samples[i], exp_c[i]); end
        end
    endtask

    task automatic test_step_ramp();
        logic signed [15:0] exp_r[5] = '{16'sd0, 16'sd16384, 16'sh8000, -16'sd16384, 16'sd0};
        run_burst(2'd1, -16'sd7, 16'd3, 8'd0, 14, 0);
        checks++;
        if (samples.size() != 3) begin failures++; $display("FAIL step_count got=%0d exp=3", samples.size()); end
        for (int i = 0; i < samples.size() && i < 3; i++) begin
            checks++;
            if (samples[i] !== -16'sd7) begin failures++; $display("FAIL step_sample[%0d] got=%0d exp=-7", i, samples[i]); end
        end
        run_burst(2'd3, 16'sd16384, 16'd5, 8'd0, 24, 0);
        checks++;
        if (samples.size() != 5) begin failures++; $display("FAIL ramp_count got=%0d exp=5", samples.size()); end
        for (int i = 0; i < samples.size() && i < 5; i++) begin
            checks++;
            if (samples[i] !== exp_r[i]) begin failures++; $display("FAIL ramp_sample[%0d] got=%0d exp=%0d", i, samples[i], exp_r[i]); end
        end
    endtask

    task automatic test_edge_cases();
        run_burst(2'd1, 16'sd3, 16'd0, 8'd0, 6, 0);
        checks += 4;
        if (samples.size() != 0) begin failures++; $display("FAIL n0_count got=%0d exp=0", samples.size()); end
        if (done_cyc != 1) begin failures++; $display("FAIL n0_done_cyc got=%0d exp=1", done_cyc); end
        if (busy_c1 !== 1'b0) begin failures++; $display("FAIL n0_busy got=%b exp=0", busy_c1); end
        if (done_cnt != 1) begin failures++; $display("FAIL n0_done_cnt got=%0d exp=1", done_cnt); end
        // Second start mid-burst must be ignored.
        run_burst(2'd1, 16'sd3, 16'd5, 8'd0, 26, 6);
        checks += 3;
        if (samples.size() != 5) begin failures++; $display("FAIL midstart_count got=%0d exp=5", samples.size()); end
        if (done_cyc != 18) begin failures++; $display("FAIL midstart_done_cyc got=%0d exp=18", done_cyc); end
        if (done_cnt != 1) begin failures++; $display("FAIL midstart_done_cnt got=%0d exp=1", done_cnt); end
        for (int i = 0; i < samples.size() && i < 5; i++) begin
            checks++;
            if (samples[i] !== 16'sd3) begin failures++; $display("FAIL midstart_sample[%0d] got=%0d exp=3", i, samples[i]); end
        end
    endtask

    task automatic test_reset_mid_burst();
        int seen = 0;
        logic done_seen = 1'b0;
        @(negedge clk);
        mode = 2'd1; amplitude = 16'sd9; num_samples = 16'd10; half_period = 8'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= 20 && seen < 3; c++) begin
            if (bus.out_valid) seen++;
            if (done) done_seen = 1'b1;
            if (seen < 3) @(negedge clk);
        end
        checks++;
        if (seen != 3) begin failures++; $display("FAIL rstmid_seen got=%0d exp=3", seen); end
        rst_n = 1'b0;
        #1;
        checks += 3;
        if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_valid got=%b exp=0", bus.out_valid); end
        if (bus.out_sample !== 16'sd0) begin failures++; $display("FAIL rstmid_sample got=%0d exp=0", bus.out_sample); end
        if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (done) done_seen = 1'b1;
        end
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (done) done_seen = 1'b1;
        end
        checks++;
        if (done_seen !== 1'b0) begin failures++; $display("FAIL rstmid_done got=%b exp=0", done_seen); end
        run_burst(2'd1, 16'sd9, 16'd10, 8'd0, 42, 0);
        checks += 2;
        if (samples.size() != 10) begin failures++; $display("FAIL rstmid_rerun_count got=%0d exp=10", samples.size()); end
        if (done_cyc != 38) begin failures++; $display("FAIL rstmid_rerun_done got=%0d exp=38", done_cyc); end
    endtask

`ifdef FIR_STIM_GEN_READY_EN
    task automatic test_backpressure();
        logic signed [15:0] exp_s[5] = '{16'sd0, 16'sd10, 16'sd20, 16'sd30, 16'sd40};
        int exp_c[5] = '{1, 5, 14, 18, 22};
        samples.delete();
        cycles.delete();
        done_cyc = -1;
        @(negedge clk);
        mode = 2'd3; amplitude = 16'sd10; num_samples = 16'd5; half_period = 8'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            bus.out_ready = !(c >= 9 && c < 14);
            if (c >= 9 && c < 14) begin
                checks++;
                if (bus.out_valid !== 1'b1 || bus.out_sample !== 16'sd20) begin
                    failures++; $display("FAIL bp_hold c=%0d valid=%b sample=%0d exp valid=1 sample=20", c, bus.out_valid, bus.out_sample);
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                samples.push_back(bus.out_sample);
                cycles.push_back(c);
            end
            if (done && done_cyc < 0) done_cyc = c;
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        checks += 2;
        if (samples.size() != 5) begin failures++; $display("FAIL bp_count got=%0d exp=5", samples.size()); end
        if (done_cyc != 23) begin failures++; $display("FAIL bp_done_cyc got=%0d exp=23", done_cyc); end
        for (int i = 0; i < samples.size() && i < 5; i++) begin
            checks += 2;
            if (samples[i] !== exp_s[i]) begin failures++; $display("FAIL bp_sample[%0d] got=%0d exp=%0d", i, samples[i], exp_s[i]); end
            if (cycles[i] != exp_c[i]) begin failures++; $display("FAIL bp_cycle[%0d] got=%0d exp=%0d", i, cycles[i], exp_c[i]); end
        end
    endtask
`endif

    initial begin
        rst_n = 1'b0; start = 1'b0; mode = 2'd0; amplitude = '0;
        num_samples = '0; half_period = '0;
`ifdef FIR_STIM_GEN_READY_EN
        bus.out_ready = 1'b1;
`endif
        test_reset();
        test_impulse();
        test_square();
        test_step_ramp();
        test_edge_cases();
        test_reset_mid_burst();
`ifdef FIR_STIM_GEN_READY_EN
        test_backpressure();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fir_stim_gen.md
Name: fir_stim_gen

Overview:
- Sample-stream transmitter that drives the FIR input interface (valid + 16-bit signed sample) from a small set of programmable test waveforms.
- Sits upstream of the fir block in bring-up and self-test builds, replacing external sample sources.
- A start pulse launches a burst of N samples at a fixed rate. done reports burst completion.

Parameters:
- DATA_W, 16, sample width in bits (signed two's complement).
- RATE_DIV, 4, clock cycles between successive samples. Must be >= 1. 1 = a sample every cycle.
- CNT_W, 16, width of the sample counter and the num_samples port.

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle burst request. Sampled only in IDLE.
- mode  in  2  waveform select: 0 impulse, 1 step, 2 square, 3 ramp. Latched on start.
- amplitude  in  DATA_W  signed amplitude / ramp increment. Latched on start.
- num_samples  in  CNT_W  burst length. Latched on start.
- half_period  in  8  square-wave half period in samples. Latched on start. 0 is treated as 1.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse at end of burst.
- out_valid  out  1  sample strobe to the FIR in_valid.
- out_sample  out  DATA_W  sample to the FIR in_sample. Forced to 0 whenever out_valid is low.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State = IDLE.
  - busy, done, out_valid = 0. out_sample = 0.
  - Sample index, rate counter and ramp accumulator = 0. Latched config = 0.
  - Reset asserted mid-burst aborts immediately. No done pulse is produced.
- States: IDLE, RUN, FINISH.
- IDLE:
  - start = 1 at edge k latches config and sets n = 0.
  - If num_samples = 0: go to FINISH. No samples are emitted.
  - Otherwise: go to RUN, with busy = 1 from edge k.
  - start while busy or in FINISH is ignored.
- RUN:
  - Sample n = 0 has out_valid high in the cycle after edge k (latency 1).
  - Each following sample is exactly RATE_DIV cycles after the previous one.
  - out_valid is a one-cycle pulse when RATE_DIV > 1. It is continuous when RATE_DIV = 1.
  - After sample n = num_samples-1 is emitted, go to FINISH.
- FINISH:
  - done = 1 and busy = 0 for exactly one cycle.
  - Then return to IDLE.
  - start is accepted again from the cycle after done.
- Waveforms, for sample index n (A = latched amplitude):
  - impulse: A at n = 0, 0 for all other n.
  - step: A for every n.
  - square: A when (n mod 2P) < P, else -A, where P = max(half_period, 1). -(-2^(DATA_W-1)) saturates to 2^(DATA_W-1)-1.
  - ramp: accumulator acc(0) = 0, acc(n+1) = acc(n) + A. Wraps modulo 2^DATA_W with no saturation.
- Counter rules:
  - The sample counter compares against the latched num_samples.
  - The full range 1..2^CNT_W-1 is supported without wrap.

Optional Feature:
- Macro FIR_STIM_GEN_READY_EN.
- Defined:
  - Adds input out_ready (1 bit) for backpressure.
  - A sample transfers when out_valid and out_ready are both high.
  - While out_ready is low, out_valid stays high and out_sample stays stable.
  - The RATE_DIV countdown to the next sample starts on the cycle after the transfer.
  - done follows the last transfer.
- Undefined:
  - No out_ready port. Every out_valid cycle is a transfer.

Decomposition:
- Shared package fir_pkg holds:
  - DATA_W default constant.
  - typedef enum logic [1:0] stim_mode_t {STIM_IMPULSE, STIM_STEP, STIM_SQUARE, STIM_RAMP}.
  - State enum stim_state_t.
  - Saturating-negate function.
- One sub-module, fir_stim_rate_div:
  - RATE_DIV down-counter with load/enable that emits a tick.
  - Reused by the FIR output decimator.

Test Plan:
- Impulse: RATE_DIV=4, mode=0, A=16'sd1, N=10 -> 10 out_valid pulses spaced 4 cycles apart, first one cycle after start, samples 1,0,0,…,0. done 1 cycle after the last sample, busy low in that cycle.
- Square: mode=2, A=100, half_period=2, N=8 -> 100,100,-100,-100,100,100,-100,-100. A=-32768 -> -32768,-32768,32767,32767.
- Ramp wrap: mode=3, A=16'sd16384, N=5 -> 0,16384,-32768,-16384,0.
- Edge cases: N=0 -> no out_valid and done the cycle after start. start pulsed mid-burst -> ignored, and the sample count stays N.
- Reset mid-burst: drop rst_n after the 3rd sample of N=10 -> out_valid, busy and out_sample go to 0 immediately with no done. A new start after reset emits the full 10 samples.
- FIR_STIM_GEN_READY_EN: hold out_ready low for 5 cycles on sample 2 -> out_valid held with a stable value. The next sample follows RATE_DIV cycles after the transfer, and the total count equals N.
